seq_muldiv: RTL
===============

Name: seq_muldiv

Overview:
- Parametrised, iterative shift-add multiply / restoring-divide unit for CPU execution units.
- Operations: unsigned multiply (MPY), signed multiply (MPYS), and unsigned 2W/W divide with overflow detection (DIV).
- Uses an explicit start/busy/done handshake in place of operand-change detection.
- Processes one operand bit per clock; operands are latched at start.

Parameters:
- WIDTH, 16, operand width W; product and dividend are 2W bits.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request pulse; accepted only when busy=0
- op  in  2  00 MPY, 01 MPYS, 10 DIV, 11 reserved
- src  in  WIDTH  multiplicand (MPY/MPYS) or divisor (DIV)
- dst  in  2*WIDTH  bits [W-1:0] are the multiplier; full 2W bits are the dividend (DIV)
- result_hi  out  WIDTH  product[2W-1:W], or quotient (DIV)
- result_lo  out  WIDTH  product[W-1:0], or remainder (DIV)
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; results valid from this cycle on
- ovf  out  1  divide overflow or reserved op; valid with done, held until next accepted start

Behaviour:
- Reset is asynchronous and active-high, taking effect immediately, including mid-operation. An in-flight operation is aborted. result_hi, result_lo, busy, done and ovf all go to 0; FSM goes to IDLE.
- FSM states: IDLE, RUN, FIX, FIN.
- Start acceptance: start=1 with busy=0 on rising edge E0 is accepted.
  - src, dst and op are latched at E0; later input changes have no effect.
  - ovf clears at E0.
  - start while busy=1 is ignored; no queueing.
- busy is high from E0 through the edge that produces done. busy is low in the done cycle, so a start in the done cycle is accepted.
- MPY:
  - RUN for exactly W iterations; each iteration adds (src shifted by i) to the 2W accumulator if multiplier bit i=1, LSB first.
  - Accumulator is 2W bits; no truncation.
  - Then FIN: done pulses in the cycle after edge E0+W+1. Latency W+1.
- MPYS:
  - Operands are two's complement. Magnitudes are latched at E0 and the product sign = sign(src) XOR sign(dst[W-1]).
  - RUN for W iterations as MPY, then one FIX cycle negating the 2W result if the sign is negative.
  - Latency W+2.
  - Most-negative x most-negative gives +2^(2W-2), exact.
- DIV:
  - At E0, compare src against dst[2W-1:W].
  - Overflow case: if src <= dst[2W-1:W] (includes src=0), go straight to FIN with ovf=1. result_hi=dst[2W-1:W], result_lo=dst[W-1:0]; dividend is passed through unchanged. Latency 1.
  - Otherwise restoring division, W RUN iterations MSB first: shift the partial remainder left by one and bring in the next dividend bit; subtract src if the W+1-bit partial remainder >= src, setting the quotient bit.
  - Then FIN: result_hi=quotient, result_lo=remainder, ovf=0. Latency W+1.
- Reserved op (11): FIN with ovf=1, results unchanged from previous values, latency 1.
- Result registers update only in the done cycle, except on reset. They hold their values until the next done or reset, and show no intermediate values during RUN.
- done is exactly one cycle wide per accepted start.

Test Plan:
- Unsigned multiply: W=16, op=00, src=0xFFFF, dst=0x0000FFFF, start at E0 -> busy for 17 cycles, done at E0+17, result={0xFFFE,0x0001}, ovf=0.
- Signed multiply: op=01, src=0xFFFF (-1), dst[15:0]=0x0002 -> done at E0+18, result={0xFFFF,0xFFFE}. Also src=dst[15:0]=0x8000 -> {0x4000,0x0000}.
- Normal divide: op=10, src=0x0002, dst=0x00010000 -> done at E0+17, result_hi=0x8000, result_lo=0x0000, ovf=0. Also src=0x0007, dst=0x00000064 -> q=0x000E, r=0x0002.
- Divide overflow: op=10, src=0x0001, dst=0x00010000 -> done at E0+1, ovf=1, result={0x0001,0x0000}. Same behaviour for src=0x0000.
- Handshake: start held high for 20 cycles with MPY -> exactly one done per accepted start, with re-acceptance in the done cycle. Change src/dst mid-operation -> result unaffected.
- Reset mid-operation: assert reset at E0+5 asynchronously (between edges) -> all outputs 0 immediately, no done. A new start after release completes normally.

Source files
------------

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative shift-add multiplier / restoring divider, one bit per clock.
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   start      in   request pulse, accepted only while busy=0
//   op         in   00 MPY, 01 MPYS, 10 DIV (2W/W unsigned), 11 reserved
//   src        in   multiplicand (MPY/MPYS) or divisor (DIV)
//   dst        in   [W-1:0] multiplier; full 2W bits are the dividend for DIV
//   result_hi  out  product[2W-1:W] or quotient
//   result_lo  out  product[W-1:0] or remainder
//   busy       out  operation in progress
//   done       out  one-cycle completion pulse
//   ovf        out  divide overflow or reserved op, held until next accepted start
module seq_muldiv #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     src,
    input  logic [2*WIDTH-1:0]   dst,
    output logic [WIDTH-1:0]     result_hi,
    output logic [WIDTH-1:0]     result_lo,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [1:0] OP_MPY  = 2'b00;
    localparam logic [1:0] OP_MPYS = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_FIN
    } state_t;

    state_t            state_q;
    logic [W2-1:0]     acc_q;
    logic [W2-1:0]     mcand_q;
    logic [WIDTH-1:0]  mplr_q;
    logic [WIDTH-1:0]  dvsr_q;
    logic [CW-1:0]     cnt_q;
    logic              is_div_q;
    logic              is_signed_q;
    logic              neg_q;
    logic              ovf_pend_q;
    logic              keep_q;

    // Operand magnitudes for signed multiply (most-negative maps to 2^(W-1), still fits W bits)
    logic [WIDTH-1:0]  src_mag_d;
    logic [WIDTH-1:0]  mplr_mag_d;
    // Datapath step results
    logic [W2-1:0]     mul_acc_d;
    logic [WIDTH:0]    prem_d;
    logic [WIDTH:0]    pdiff_d;
    logic              qbit_d;
    logic [WIDTH-1:0]  rem_d;
    logic [W2-1:0]     div_acc_d;

    always_comb begin
        src_mag_d  = src;
        mplr_mag_d = dst[WIDTH-1:0];
        if (op == OP_MPYS) begin
            if (src[WIDTH-1])
                src_mag_d = -src;
            if (dst[WIDTH-1])
                mplr_mag_d = -dst[WIDTH-1:0];
        end
    end

    // One shift-add multiply step and one restoring-divide step.
    // Divide packs {partial remainder, dividend bits left / quotient bits} into acc_q.
    always_comb begin
        mul_acc_d = acc_q + (mplr_q[0] ? mcand_q : '0);
        prem_d    = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
        pdiff_d   = prem_d - {1'b0, dvsr_q};
        qbit_d    = (prem_d >= {1'b0, dvsr_q});
        rem_d     = qbit_d ? pdiff_d[WIDTH-1:0] : prem_d[WIDTH-1:0];
        div_acc_d = {rem_d, acc_q[WIDTH-2:0], qbit_d};
    end

    // Control FSM and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplr_q      <= '0;
            dvsr_q      <= '0;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            neg_q       <= 1'b0;
            ovf_pend_q  <= 1'b0;
            keep_q      <= 1'b0;
            result_hi   <= '0;
            result_lo   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        ovf         <= 1'b0;
                        cnt_q       <= '0;
                        is_div_q    <= 1'b0;
                        is_signed_q <= 1'b0;
                        neg_q       <= 1'b0;
                        ovf_pend_q  <= 1'b0;
                        keep_q      <= 1'b0;
                        case (op)
                            OP_MPY, OP_MPYS: begin
                                acc_q       <= '0;
                                mcand_q     <= {{WIDTH{1'b0}}, src_mag_d};
                                mplr_q      <= mplr_mag_d;
                                is_signed_q <= (op == OP_MPYS);
                                neg_q       <= (op == OP_MPYS) && (src[WIDTH-1] ^ dst[WIDTH-1]);
                                state_q     <= S_RUN;
                            end
                            OP_DIV: begin
                                acc_q    <= dst;
                                dvsr_q   <= src;
                                is_div_q <= 1'b1;
                                // Quotient would not fit in W bits: pass dividend through
                                if (src <= dst[W2-1:WIDTH]) begin
                                    ovf_pend_q <= 1'b1;
                                    state_q    <= S_FIN;
                                end else begin
                                    state_q <= S_RUN;
                                end
                            end
                            default: begin
                                keep_q     <= 1'b1;
                                ovf_pend_q <= 1'b1;
                                state_q    <= S_FIN;
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    if (is_div_q) begin
                        acc_q <= div_acc_d;
                    end else begin
                        acc_q   <= mul_acc_d;
                        mcand_q <= mcand_q << 1;
                        mplr_q  <= mplr_q >> 1;
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER)
                        state_q <= is_signed_q ? S_FIX : S_FIN;
                end
                S_FIX: begin
                    if (neg_q)
                        acc_q <= -acc_q;
                    state_q <= S_FIN;
                end
                S_FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    ovf     <= ovf_pend_q;
                    state_q <= S_IDLE;
                    if (!keep_q) begin
                        if (is_div_q && !ovf_pend_q) begin
                            result_hi <= acc_q[WIDTH-1:0];
                            result_lo <= acc_q[W2-1:WIDTH];
                        end else begin
                            result_hi <= acc_q[W2-1:WIDTH];
                            result_lo <= acc_q[WIDTH-1:0];
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
